// File: rtl/menu_navigator.sv
// Front-panel mode navigator: left/right select a function, enter hands it control,
// return takes it back; the selected display bus is registered onto one ledScan bus.
// Optional inactivity auto-return is enabled by defining IDLE_TIMEOUT_EN.
module menu_navigator #(
    parameter int          N_MODES        = 4,
    parameter int          N_DIGITS       = 8,
    parameter int          RESET_MODE     = 0,
    parameter int          WRAP           = 1,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd3000000000,
    parameter int          MODE_W         = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            btn_left,
    input  logic                            btn_right,
    input  logic                            btn_enter,
    input  logic                            btn_return,
    input  logic [N_MODES*N_DIGITS*4-1:0]   ch_digits,
    input  logic [N_MODES*N_DIGITS-1:0]     ch_point,
    input  logic [N_MODES-1:0]              ch_shine,
    input  logic [N_MODES*N_DIGITS-1:0]     ch_which_shine,
    output logic [MODE_W-1:0]               mode_sel,
    output logic                            entered,
    output logic [MODE_W-1:0]               active_mode,
    output logic                            enter_pulse,
    output logic                            return_pulse,
    output logic [N_DIGITS*4-1:0]           disp_digits,
    output logic [N_DIGITS-1:0]             disp_point,
    output logic                            disp_shine,
    output logic [N_DIGITS-1:0]             disp_which_shine
);

    typedef enum logic {SWITCH, ENTER} state_t;

    state_t                  state_q, state_d;
    logic [MODE_W-1:0]       mode_sel_q, mode_sel_d;
    logic                    armed_q, armed_d;
    logic                    enter_pulse_q, enter_pulse_d;
    logic                    return_pulse_q, return_pulse_d;
    logic [N_DIGITS*4-1:0]   disp_digits_q, disp_digits_d;
    logic [N_DIGITS-1:0]     disp_point_q, disp_point_d;
    logic                    disp_shine_q, disp_shine_d;
    logic [N_DIGITS-1:0]     disp_which_shine_q, disp_which_shine_d;
    logic                    any_btn;
    logic                    timeout;
    logic [3:0]              mode_code;

    localparam logic [MODE_W-1:0] LAST_MODE  = MODE_W'(N_MODES - 1);
    localparam logic [MODE_W-1:0] RESET_SEL  = MODE_W'(RESET_MODE);
    localparam logic [3:0]        RESET_CODE = 4'(RESET_MODE);

    assign any_btn = btn_left | btn_right | btn_enter | btn_return;

`ifdef IDLE_TIMEOUT_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = '0;
        timeout    = 1'b0;
        if (state_q == ENTER && !any_btn) begin
            if (idle_cnt_q == TIMEOUT_CYCLES - 32'd1) begin
                timeout = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Navigation FSM; armed re-arms only after a full release so each press acts once.
    always_comb begin
        state_d        = state_q;
        mode_sel_d     = mode_sel_q;
        armed_d        = armed_q | ~any_btn;
        enter_pulse_d  = 1'b0;
        return_pulse_d = 1'b0;
        case (state_q)
            SWITCH: begin
                if (armed_q) begin
                    if (btn_enter) begin
                        state_d       = ENTER;
                        enter_pulse_d = 1'b1;
                        armed_d       = 1'b0;
                    end else if (btn_right && !btn_left) begin
                        armed_d = 1'b0;
                        if (mode_sel_q == LAST_MODE) begin
                            mode_sel_d = (WRAP != 0) ? '0 : mode_sel_q;
                        end else begin
                            mode_sel_d = mode_sel_q + MODE_W'(1);
                        end
                    end else if (btn_left && !btn_right) begin
                        armed_d = 1'b0;
                        if (mode_sel_q == '0) begin
                            mode_sel_d = (WRAP != 0) ? LAST_MODE : mode_sel_q;
                        end else begin
                            mode_sel_d = mode_sel_q - MODE_W'(1);
                        end
                    end else if (btn_left && btn_right) begin
                        armed_d = 1'b0;
                    end
                end
            end
            ENTER: begin
                if (armed_q && btn_return) begin
                    state_d        = SWITCH;
                    return_pulse_d = 1'b1;
                    armed_d        = 1'b0;
                end else if (timeout) begin
                    state_d        = SWITCH;
                    return_pulse_d = 1'b1;
                end
            end
            default: state_d = SWITCH;
        endcase
    end

    // Display source follows the current (registered) state, giving one cycle of latency.
    assign mode_code = 4'(mode_sel_q);

    always_comb begin
        disp_digits_d      = {N_DIGITS{mode_code}};
        disp_point_d       = '1;
        disp_shine_d       = 1'b0;
        disp_which_shine_d = '0;
        if (state_q == ENTER) begin
            for (int m = 0; m < N_MODES; m++) begin
                if (mode_sel_q == MODE_W'(m)) begin
                    disp_digits_d      = ch_digits[m*N_DIGITS*4 +: N_DIGITS*4];
                    disp_point_d       = ch_point[m*N_DIGITS +: N_DIGITS];
                    disp_shine_d       = ch_shine[m];
                    disp_which_shine_d = ch_which_shine[m*N_DIGITS +: N_DIGITS];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= SWITCH;
            mode_sel_q         <= RESET_SEL;
            armed_q            <= 1'b0;
            enter_pulse_q      <= 1'b0;
            return_pulse_q     <= 1'b0;
            disp_digits_q      <= {N_DIGITS{RESET_CODE}};
            disp_point_q       <= '1;
            disp_shine_q       <= 1'b0;
            disp_which_shine_q <= '0;
        end else begin
            state_q            <= state_d;
            mode_sel_q         <= mode_sel_d;
            armed_q            <= armed_d;
            enter_pulse_q      <= enter_pulse_d;
            return_pulse_q     <= return_pulse_d;
            disp_digits_q      <= disp_digits_d;
            disp_point_q       <= disp_point_d;
            disp_shine_q       <= disp_shine_d;
            disp_which_shine_q <= disp_which_shine_d;
        end
    end

    assign mode_sel         = mode_sel_q;
    assign entered          = (state_q == ENTER);
    assign active_mode      = (state_q == ENTER) ? mode_sel_q : '1;
    assign enter_pulse      = enter_pulse_q;
    assign return_pulse     = return_pulse_q;
    assign disp_digits      = disp_digits_q;
    assign disp_point       = disp_point_q;
    assign disp_shine       = disp_shine_q;
    assign disp_which_shine = disp_which_shine_q;

endmodule
